// File: rtl/uart_cmd_regbank_if.sv
// UART byte interface between the receiver/transmitter pair and the command
// decoder.
//   rx_ready : receiver byte-available level (rising edge = new byte)
//   rx_data  : received byte, valid while rx_ready is high
//   tx_ready : transmitter can accept a byte
//   tx_valid : read-back byte valid
//   tx_data  : read-back byte
// master = UART side, slave = command decoder.
interface uart_cmd_regbank_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        output rx_ready, rx_data, tx_ready,
        input  tx_valid, tx_data
    );

    modport slave (
        input  rx_ready, rx_data, tx_ready,
        output tx_valid, tx_data
    );
endinterface

// File: rtl/uart_cmd_regbank.sv
// UART command decoder and control-register bank.
// Frames: SYNC_BYTE, ADDR (bit7 = read, bits6:0 = index), REG_W/8 payload
// bytes MSB first (writes only), optional CSUM byte.
// Optional feature macro: CMD_CHECKSUM_EN (trailing XOR checksum byte).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : UART byte interface (slave modport)
//   regs      : flat register bank, register i at [i*REG_W +: REG_W]
//   wr_stb    : one-cycle pulse per register written
//   ack, err  : one-cycle command accepted / frame rejected pulses
//   err_code  : cause of last error (1 timeout, 2 checksum, 3 index, 4 busy)
//
// state   | meaning
// IDLE    | waiting for SYNC_BYTE
// ADDR    | waiting for address byte
// DATA    | collecting payload bytes
// CSUM    | waiting for checksum byte
// COMMIT  | index check, register write or read latch
// READ_TX | streaming read-back bytes to the transmitter
module uart_cmd_regbank #(
    parameter int                         NUM_REGS       = 64,
    parameter int                         REG_W          = 32,
    parameter logic [7:0]                 SYNC_BYTE      = 8'h01,
    parameter int                         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [NUM_REGS*REG_W-1:0]  RESET_VALUES   = '0,
    parameter logic [NUM_REGS-1:0]        PULSE_MASK     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_cmd_regbank_if.slave         bus,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic [NUM_REGS-1:0]       wr_stb,
    output logic                      ack,
    output logic                      err,
    output logic [2:0]                err_code
);
    localparam int              NB         = REG_W / 8;
    localparam int              TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BYTE  = 4'(NB - 1);
    localparam logic [7:0]      NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, COMMIT, READ_TX} state_t;

`ifdef CMD_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    localparam state_t AFTER_PAYLOAD = COMMIT;
`endif

    state_t           state;
    logic             rx_prev;
    logic             acc;
    logic [7:0]       byte_q;
    logic [7:0]       addr_q;
    logic [3:0]       byte_cnt;
    logic [TMR_W-1:0] tmr;
    logic [REG_W-1:0] data_sr;
    logic [REG_W-1:0] tx_sr;
    logic [REG_W-1:0] rd_val;
    logic             idx_bad;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       csum;
    logic             csum_bad;
`endif

    assign idx_bad = {1'b0, addr_q[6:0]} >= NUM_REGS_B;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_q[6:0] == 7'(i)) rd_val = regs[i*REG_W +: REG_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_prev      <= 1'b0;
            acc          <= 1'b0;
            byte_q       <= '0;
            addr_q       <= '0;
            byte_cnt     <= '0;
            tmr          <= '0;
            data_sr      <= '0;
            tx_sr        <= '0;
            regs         <= RESET_VALUES;
            wr_stb       <= '0;
            ack          <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
`ifdef CMD_CHECKSUM_EN
            csum         <= '0;
            csum_bad     <= 1'b0;
`endif
        end else begin
            // Registered edge detect: acc/byte_q describe the byte seen one cycle ago.
            rx_prev <= bus.rx_ready;
            acc     <= bus.rx_ready & ~rx_prev;
            byte_q  <= bus.rx_data;
            wr_stb  <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;

            // Strobe registers fall back to their reset value unless rewritten below.
            for (int i = 0; i < NUM_REGS; i++)
                if (PULSE_MASK[i]) regs[i*REG_W +: REG_W] <= RESET_VALUES[i*REG_W +: REG_W];

            // Inter-byte timer: reloaded per byte, counts down while a frame is open.
            if (acc)
                tmr <= TMR_LOAD;
            else if ((state == ADDR || state == DATA || state == CSUM) && tmr != '0)
                tmr <= tmr - 1'b1;

            // Bytes arriving while busy are dropped; a commit error below takes precedence.
            if (acc && (state == COMMIT || state == READ_TX)) begin
                err      <= 1'b1;
                err_code <= 3'd4;
            end

            case (state)
                IDLE: begin
                    if (acc && byte_q == SYNC_BYTE) state <= ADDR;
                end
                ADDR: begin
                    if (acc) begin
                        addr_q   <= byte_q;
                        byte_cnt <= '0;
`ifdef CMD_CHECKSUM_EN
                        csum     <= byte_q;
`endif
                        state    <= byte_q[7] ? AFTER_PAYLOAD : DATA;
                    end else if (tmr == '0) begin
                        err      <= 1'b1;
                        err_code <= 3'd1;
                        state    <= IDLE;
                    end
                end
                DATA: begin
                    if (acc) begin
                        data_sr <= (data_sr << 8) | REG_W'(byte_q);
`ifdef CMD_CHECKSUM_EN
                        csum    <= csum ^ byte_q;
`endif
                        if (byte_cnt == LAST_BYTE) state <= AFTER_PAYLOAD;
                        else byte_cnt <= byte_cnt + 1'b1;
                    end else if (tmr == '0) begin
                        err      <= 1'b1;
                        err_code <= 3'd1;
                        state    <= IDLE;
                    end
                end
                CSUM: begin
`ifdef CMD_CHECKSUM_EN
                    if (acc) begin
                        csum_bad <= (byte_q != csum);
                        state    <= COMMIT;
                    end else if (tmr == '0) begin
                        err      <= 1'b1;
                        err_code <= 3'd1;
                        state    <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                COMMIT: begin
`ifdef CMD_CHECKSUM_EN
                    if (csum_bad) begin
                        err      <= 1'b1;
                        err_code <= 3'd2;
                        state    <= IDLE;
                    end else
`endif
                    if (idx_bad) begin
                        err      <= 1'b1;
                        err_code <= 3'd3;
                        state    <= IDLE;
                    end else if (!addr_q[7]) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q[6:0] == 7'(i)) begin
                                regs[i*REG_W +: REG_W] <= data_sr;
                                wr_stb[i]              <= 1'b1;
                            end
                        end
                        ack   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ack          <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= rd_val[REG_W-1 -: 8];
                        tx_sr        <= rd_val << 8;
                        byte_cnt     <= '0;
                        state        <= READ_TX;
                    end
                end
                READ_TX: begin
                    if (bus.tx_valid && bus.tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            bus.tx_valid <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            bus.tx_data <= tx_sr[REG_W-1 -: 8];
                            tx_sr       <= tx_sr << 8;
                            byte_cnt    <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_regbank.sv
module tb_uart_cmd_regbank;
    localparam int NUM_REGS = 64;
    localparam int REG_W    = 32;
    localparam int TIMEOUT  = 64;
    localparam int FLAT_W   = NUM_REGS * REG_W;
    localparam logic [FLAT_W-1:0] RV =
        (FLAT_W'(32'hA5A5_0003) << (3 * 32)) | (FLAT_W'(32'h0000_0700) << (22 * 32));
    localparam logic [NUM_REGS-1:0] PM = (NUM_REGS'(1) << 21) | (NUM_REGS'(1) << 22);

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;
    localparam int K_TX  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [FLAT_W-1:0]   regs;
    logic [NUM_REGS-1:0] wr_stb;
    logic                ack;
    logic                err;
    logic [2:0]          err_code;

    uart_cmd_regbank_if bus();

    uart_cmd_regbank #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .SYNC_BYTE(8'h01),
        .TIMEOUT_CYCLES(TIMEOUT), .RESET_VALUES(RV), .PULSE_MASK(PM)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .regs(regs), .wr_stb(wr_stb),
        .ack(ack), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                gap    = 0;
    logic [FLAT_W-1:0] exp_regs;
    logic              hold_prev = 1'b0;
    logic [7:0]        hold_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_regs(input string name);
        checks++;
        if (regs !== exp_regs) begin
            errors++;
            for (int i = 0; i < NUM_REGS; i++)
                if (regs[i*REG_W +: REG_W] !== exp_regs[i*REG_W +: REG_W]) begin
                    $display("FAIL %s: regs[%0d] got %h expected %h", name, i,
                             regs[i*REG_W +: REG_W], exp_regs[i*REG_W +: REG_W]);
                    break;
                end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick;
        bus.rx_ready = 1'b0;
        tick;
        tick;
        repeat (gap) tick;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [31:0] data);
        logic [7:0] cs;
        cs = addr;
        send_byte(8'h01);
        send_byte(addr);
        if (!addr[7]) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(data[k*8 +: 8]);
                cs = cs ^ data[k*8 +: 8];
            end
        end
`ifdef CMD_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic write_reg(input int idx, input logic [31:0] data);
        expect_ev(K_WR, 32'(idx));
        send_frame(8'(idx), data);
        if (!PM[idx]) exp_regs[idx*REG_W +: REG_W] = data;
    endtask

    task automatic pop_expect(input int kind, input string what, output exp_t e, output bit ok);
        ok = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got event with empty queue, required none", what);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                checks++;
                errors++;
                $display("FAIL event_order: got %s, required event kind %0d", what, e.kind);
            end else ok = 1'b1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst) begin
            if (hold_prev) begin
                check("tx_hold_valid", 64'(bus.tx_valid), 64'd1);
                check("tx_hold_data", 64'(bus.tx_data), 64'(hold_data));
            end
            hold_prev = bus.tx_valid && !bus.tx_ready;
            hold_data = bus.tx_data;
            if (ack) begin
                if (sb.size() != 0 && sb[0].kind == K_RD) begin
                    pop_expect(K_RD, "ack", e, ok);
                    check("ack_read_wr_stb", 64'(wr_stb), 64'd0);
                end else begin
                    pop_expect(K_WR, "ack", e, ok);
                    if (ok) check("ack_wr_stb", 64'(wr_stb), 64'd1 << e.val);
                end
            end else if (wr_stb != '0) begin
                check("wr_stb_without_ack", 64'(wr_stb), 64'd0);
            end
            if (err) begin
                pop_expect(K_ERR, "err", e, ok);
                if (ok) begin
                    check("err_code", 64'(err_code), 64'(e.val));
                    check("err_wr_stb", 64'(wr_stb), 64'd0);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                pop_expect(K_TX, "tx_byte", e, ok);
                if (ok) check("tx_byte", 64'(bus.tx_data), 64'(e.val));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] raw[$];
        bus.rx_ready = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b1;
        exp_regs     = RV;
        repeat (3) tick;

        // Reset state
        check_regs("reset_regs");
        check("reset_wr_stb", 64'(wr_stb), 64'd0);
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_err_code", 64'(err_code), 64'd0);
        check("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("reset_tx_data", 64'(bus.tx_data), 64'd0);
        rst = 1'b0;
        tick;

        // Plain write, others unchanged
        write_reg(5, 32'h0000_03E8);
        check("reg5_write", 64'(regs[5*REG_W +: REG_W]), 64'h3E8);
        check_regs("after_write5");

        // Strobe registers: written value for one cycle, then reset value
        write_reg(21, 32'h1);
        check("pulse21_first", 64'(regs[21*REG_W +: REG_W]), 64'h1);
        tick;
        check("pulse21_after", 64'(regs[21*REG_W +: REG_W]), 64'h0);
        write_reg(22, 32'h0000_FFFF);
        check("pulse22_first", 64'(regs[22*REG_W +: REG_W]), 64'hFFFF);
        tick;
        check("pulse22_after", 64'(regs[22*REG_W +: REG_W]), 64'h700);
        check_regs("after_pulses");

        // Read-back with rx_ready held high on ADDR and tx_ready toggling
        expect_ev(K_RD, 32'd5);
        expect_ev(K_TX, 32'h00);
        expect_ev(K_TX, 32'h00);
        expect_ev(K_TX, 32'h03);
        expect_ev(K_TX, 32'hE8);
        fork
            begin
                send_byte(8'h01);
                bus.rx_data  = 8'h85;
                bus.rx_ready = 1'b1;
                repeat (8) tick;
                bus.rx_ready = 1'b0;
                tick;
`ifdef CMD_CHECKSUM_EN
                send_byte(8'h85);
`endif
            end
            begin
                repeat (40) begin
                    bus.tx_ready = ~bus.tx_ready;
                    tick;
                end
                bus.tx_ready = 1'b1;
            end
        join
        tick;

        // Index out of range
        expect_ev(K_ERR, 32'd3);
        send_frame(8'h45, 32'hDEAD_BEEF);
        check_regs("after_bad_index");

        // Inter-byte timeout, then a valid frame
        expect_ev(K_ERR, 32'd1);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        repeat (TIMEOUT + 16) tick;
        check_regs("after_timeout");
        write_reg(7, 32'hCAFE_F00D);
        check_regs("after_write7");

        // Gaps just under the timeout, SYNC values inside the payload
        gap = TIMEOUT - 14;
        write_reg(8, 32'h0101_0101);
        gap = 0;
        check("reg8_sync_payload", 64'(regs[8*REG_W +: REG_W]), 64'h0101_0101);

        // Byte arriving during READ_TX is dropped, read-back continues
        bus.tx_ready = 1'b0;
        expect_ev(K_RD, 32'd7);
        expect_ev(K_ERR, 32'd4);
        expect_ev(K_TX, 32'hCA);
        expect_ev(K_TX, 32'hFE);
        expect_ev(K_TX, 32'hF0);
        expect_ev(K_TX, 32'h0D);
        send_frame(8'h87, 32'h0);
        send_byte(8'h55);
        repeat (2) tick;
        bus.tx_ready = 1'b1;
        repeat (10) tick;

`ifdef CMD_CHECKSUM_EN
        // Hand-computed checksums
        expect_ev(K_WR, 32'd5);
        raw = '{8'h01, 8'h05, 8'h00, 8'h00, 8'h03, 8'hE8, 8'hEE};
        foreach (raw[k]) send_byte(raw[k]);
        check("csum_good_reg5", 64'(regs[5*REG_W +: REG_W]), 64'h3E8);
        expect_ev(K_ERR, 32'd2);
        raw = '{8'h01, 8'h05, 8'h00, 8'h00, 8'h07, 8'h77, 8'hEF};
        foreach (raw[k]) send_byte(raw[k]);
        check("csum_bad_reg5", 64'(regs[5*REG_W +: REG_W]), 64'h3E8);
`endif

        // Reset after the third payload byte
        send_byte(8'h01);
        send_byte(8'h06);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_regs = RV;
        check_regs("after_midframe_reset");
        check("midframe_reset_err_code", 64'(err_code), 64'd0);
        check("midframe_reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        repeat (12) tick;
        write_reg(6, 32'h600D_600D);
        check_regs("after_reset_write6");

        repeat (4) tick;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_regbank.md
# uart_cmd_regbank

Parametrised UART command decoder and control-register bank for the host-to-FPGA parameter path. It takes bytes from the UART receiver, assembles framed write/read commands, and updates a bank of `NUM_REGS` registers of `REG_W` bits. Those registers drive sync/pulse/detector timing, DAC and image-load controls. It adds five things:
- per-register reset values;
- self-clearing strobe registers;
- an inter-byte timeout;
- address checking;
- register read-back through the UART transmitter.

## Interface
Parameters:
- `NUM_REGS`, 64: number of registers; must be 1..128.
- `REG_W`, 32: register width; multiple of 8, 8..64. `NB = REG_W/8` payload bytes.
- `SYNC_BYTE`, 8'h01: frame start byte.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clk cycles between bytes inside a frame.
- `RESET_VALUES`, all zero: `NUM_REGS*REG_W` flat vector. Register i occupies slice `[i*REG_W +: REG_W]`.
- `PULSE_MASK`, all zero: `NUM_REGS` bits. A set bit makes that register a one-cycle strobe.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_ready` in 1: UART byte-available level; a byte is taken on its rising edge.
- `rx_data` in 8: received byte, valid while `rx_ready` is high.
- `tx_ready` in 1: transmitter can accept a byte.
- `tx_valid` out 1: read-back byte valid.
- `tx_data` out 8: read-back byte.
- `regs` out `NUM_REGS*REG_W`: flat register bank.
- `wr_stb` out `NUM_REGS`: one-cycle pulse per register written.
- `ack` out 1: one-cycle pulse on a successful command.
- `err` out 1: one-cycle pulse on a rejected frame.
- `err_code` out 3: cause of the last error; held until the next error.

## Operation
- A byte is "accepted" when `rx_ready` is 1 now and was 0 on the previous cycle. Edge detection is internal, with one register stage.
- Frame format: `SYNC_BYTE`, then ADDR, then `NB` payload bytes MSB first (write frames only), then CSUM (only with the macro).
  - ADDR[7] = 0: write. ADDR[7] = 1: read. ADDR[6:0] is the register index.
  - A read frame has no payload.
- States: IDLE, ADDR, DATA, CSUM, COMMIT, READ_TX.
  - IDLE: an accepted byte equal to `SYNC_BYTE` moves to ADDR. Any other byte is silently discarded.
  - ADDR: capture the byte. A write goes to DATA with the byte counter at 0. A read goes to CSUM when the macro is defined, otherwise to COMMIT.
  - DATA: shift each byte into the data shift register. After the `NB`-th byte, go to CSUM or COMMIT.
  - CSUM: compare the byte against the running XOR, then go to COMMIT.
  - COMMIT (one cycle):
    - If index ≥ `NUM_REGS`: `err_code` = 3, `err` pulses, go to IDLE.
    - Else if write: load the register, pulse `wr_stb[index]` and `ack`, go to IDLE.
    - Else (read): latch the register value, pulse `ack`, go to READ_TX.
  - READ_TX: present `NB` bytes MSB first. Advance on `tx_valid && tx_ready`. Go to IDLE after the last byte.
- PULSE_MASK registers take the written value for exactly one cycle, then return to their RESET_VALUES slice.
- Timeout: a counter clears on every accepted byte and runs in states ADDR, DATA and CSUM. On reaching `TIMEOUT_CYCLES-1`: `err_code` = 1, `err` pulses, go to IDLE, and nothing is written.
- A byte accepted during COMMIT or READ_TX is dropped: `err_code` = 4, `err` pulses, the state is unchanged.
- Byte values are never interpreted while in DATA or CSUM, so `SYNC_BYTE` values are legal payload.

## Timing
- Reset values:
  - `regs` = `RESET_VALUES`;
  - `wr_stb`, `ack`, `err`, `tx_valid` = 0;
  - `tx_data` = 0, `err_code` = 0;
  - state = IDLE, all counters 0.
- Reset mid-frame or mid-READ_TX aborts immediately. No partial write occurs, and `tx_valid` drops on the next edge.
- Latency from the rising edge of `rx_ready` carrying the last frame byte:
  - byte accepted after 1 cycle;
  - COMMIT in the following cycle;
  - `regs`, `wr_stb` and `ack` visible 3 cycles after that rising edge.
- `wr_stb`, `ack` and `err` are high for exactly one cycle.
- Read-back: `tx_valid` rises the cycle after COMMIT. `tx_data` is stable while `tx_valid && !tx_ready`. The next byte follows on the cycle after a handshake.
- `rx_ready` held high produces exactly one accepted byte.

## Configuration
- `CMD_CHECKSUM_EN` defined: every frame carries a trailing CSUM byte. CSUM is the XOR of ADDR and all payload bytes (SYNC excluded). On mismatch: `err_code` = 2, `err` pulses, no write and no read-back, go to IDLE.
- Undefined: the CSUM state is never entered. The frame ends after the last payload byte, or after ADDR for reads.

## Test plan
1. Write (macro undefined, default params): send 01,05,00,00,03,E8 → `regs[5]` = 32'h3E8, a single `wr_stb[5]` pulse, `ack` pulse, and all other registers unchanged.
2. Strobe: set `PULSE_MASK[21]`, `RESET_VALUES[21]` = 0, write 1 to reg 21 → `regs[21]` = 1 for exactly one cycle, then 0.
3. Read-back: after test 1, send 01,85 with `tx_ready` toggling 1/0 → `tx_data` sequence 00,00,03,E8, each byte held while `tx_ready` is low.
4. Errors:
   - send 01,45,… (index 69) → `err_code` 3, no `wr_stb`;
   - send 01,05,00 then idle for `TIMEOUT_CYCLES` → `err_code` 1; a following valid frame is accepted normally.
5. With `CMD_CHECKSUM_EN`: 01,05,00,00,03,E8,EE → write and `ack`; same frame with checksum EF → `err_code` 2, `regs[5]` unchanged.
6. Assert `rst` after the 3rd payload byte → `regs` = `RESET_VALUES`, state IDLE, and no `wr_stb` or `ack` afterwards.
